bcd_digit_reader: RTL

Read-side counterpart of the keypad digit writer. On a Start pulse it reads the stored BCD digits from the 4-word digit memory, from address 0 up to DEPTH-1. It decodes each digit back to a 10-bit one-hot key code and presents each code to a downstream consumer over a valid/ready handshake. It drives the memory address and read/write lines while Busy; an external mux selects between writer and reader.

---
 rtl/bcd_rd_pkg.sv | 19 +
 rtl/bcd_to_dec.sv | 24 ++
 rtl/bcd_digit_reader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/bcd_rd_pkg.sv
// -----------------------------------------------------------------------------
// bcd_rd_pkg
// Shared definitions for the BCD digit reader: the reader FSM state encoding
// and the digit/one-hot code widths used by the decoder and the top level.
// -----------------------------------------------------------------------------
package bcd_rd_pkg;

    typedef enum logic [2:0] {
        IDLE,   // waiting for Start
        RD,     // address presented to memory
        CAP,    // read data available, decoded into Dec
        OUT,    // Dec/Dv offered to the consumer
        FIN     // one-cycle Done pulse
    } state_t;

    localparam int BCD_MAX = 9;   // largest legal BCD digit
    localparam int DEC_W   = 10;  // one-hot code width, one bit per digit

endpackage : bcd_rd_pkg

// File: rtl/bcd_to_dec.sv
// -----------------------------------------------------------------------------
// bcd_to_dec
// Combinational 4-bit BCD digit to 10-bit one-hot key code. Digit k sets
// bit k; codes 10..15 are not digits and produce an all-zero output.
//
// Ports:
//   bcd  in   4      BCD digit
//   dec  out  DEC_W  one-hot code (all zero for invalid input)
// -----------------------------------------------------------------------------
module bcd_to_dec
    import bcd_rd_pkg::*;
(
    input  logic [3:0]       bcd,
    output logic [DEC_W-1:0] dec
);

    always_comb begin
        dec = '0;
        if (bcd <= 4'(BCD_MAX)) begin
            dec = DEC_W'(1) << bcd;
        end
    end

endmodule : bcd_to_dec

// File: rtl/bcd_digit_reader.sv
// -----------------------------------------------------------------------------
// bcd_digit_reader
// Read-side partner of the keypad digit writer. A Start pulse walks the digit
// memory from address 0 to DEPTH-1, decodes each stored BCD digit to a
// one-hot key code and hands it to a consumer over a Dv/Rdy handshake.
// The memory address is driven while Busy; an external mux chooses between
// writer and reader.
//
// Optional build macro:
//   ERR_CHECK_EN  when defined, digits >9 set the sticky Err flag and are
//                 skipped instead of being presented as Dec=0.
//
// Ports:
//   CLK    in   1       rising-edge clock
//   RST    in   1       asynchronous active-low reset
//   Start  in   1       begin a read sequence (ignored while Busy)
//   AD     out  ADDR_W  memory address
//   RW     out  1       memory read/write select, always read (0)
//   Din    in   DATA_W  memory read data, valid the cycle after AD
//   Dec    out  10      one-hot decoded digit
//   Dv     out  1       Dec valid
//   Rdy    in   1       consumer ready; transfer when Dv && Rdy at an edge
//   Busy   out  1       sequence in progress
//   Done   out  1       one-cycle pulse after the last digit
//   Err    out  1       sticky invalid-digit flag (0 unless ERR_CHECK_EN)
//
// DATA_W is expected to be 4; only the low nibble of Din is decoded.
// -----------------------------------------------------------------------------
module bcd_digit_reader
    import bcd_rd_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Start,
    output logic [ADDR_W-1:0] AD,
    output logic              RW,
    input  logic [DATA_W-1:0] Din,
    output logic [DEC_W-1:0]  Dec,
    output logic              Dv,
    input  logic              Rdy,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ad_q,    ad_d;
    logic [DEC_W-1:0]    dec_q,   dec_d;
    logic                dv_q,    dv_d;
    logic                err_q,   err_d;

    logic [DEC_W-1:0]    dec_w;
    logic                last_addr;

    bcd_to_dec u_dec (
        .bcd (Din[3:0]),
        .dec (dec_w)
    );

    assign last_addr = (ad_q == ADDR_W'(DEPTH - 1));

    // Next-state and datapath update.
    // NOTE: every signal gets its hold value before the case so no path
    // leaves one unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        state_d = state_q;
        ad_d    = ad_q;
        dec_d   = dec_q;
        dv_d    = dv_q;
        err_d   = err_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    ad_d    = '0;
                    err_d   = 1'b0;
                    state_d = RD;
                end
            end

            RD: begin
                state_d = CAP;
            end

            CAP: begin
`ifdef ERR_CHECK_EN
                // An all-zero decode means the word was not a digit: flag
                // it and move on as though it had been consumed.
                if (dec_w == '0) begin
                    err_d = 1'b1;
                    if (last_addr) begin
                        state_d = FIN;
                    end else begin
                        ad_d    = ad_q + ADDR_W'(1);
                        state_d = RD;
                    end
                end else begin
                    dec_d   = dec_w;
                    dv_d    = 1'b1;
                    state_d = OUT;
                end
`else
                dec_d   = dec_w;
                dv_d    = 1'b1;
                state_d = OUT;
`endif
            end

            OUT: begin
                // Dv is always high here, so Rdy alone marks the transfer.
                if (Rdy) begin
                    dv_d = 1'b0;
                    if (last_addr) begin
                        state_d = FIN;
                    end else begin
                        ad_d    = ad_q + ADDR_W'(1);
                        state_d = RD;
                    end
                end
            end

            FIN: begin
                // Start in this cycle is deliberately dropped.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            ad_q    <= '0;
            dec_q   <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ad_q    <= ad_d;
            dec_q   <= dec_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
        end
    end

    assign AD   = ad_q;
    assign RW   = 1'b0;
    assign Dec  = dec_q;
    assign Dv   = dv_q;
    assign Busy = (state_q != IDLE);
    assign Done = (state_q == FIN);
    assign Err  = err_q;

endmodule : bcd_digit_reader
